// File: rtl/decryptor.sv
// Modular exponentiation decryptor: plain = cipher^d mod n, constant-latency square-and-multiply.
// Optional DECRYPTOR_CHECK_EN builds a comparator driving match against a latched plain_ref.
module decryptor #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] cipher,
  input  logic [WIDTH-1:0] plain_ref,
  output logic [WIDTH-1:0] plain,
  output logic             valid,
  output logic             busy,
  output logic             err,
  output logic             match
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | operand check, accumulator init
  // SQUARE | acc = acc*acc mod n (WIDTH+1 cycles)
  // MULT   | t = acc*cipher mod n, keep if exponent bit set (WIDTH+1 cycles)
  // DONE   | results valid for one cycle
  typedef enum logic [2:0] {IDLE, LOAD, SQUARE, MULT, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] d_q, n_q, c_q, acc, p;
  logic [CW-1:0]    cnt, bit_idx, step_idx;
  logic             op_err, a_bit, d_bit, mul_last, last_bit;
  logic [WIDTH-1:0] mul_b, p_nx, res;
  logic [WIDTH+1:0] sum, sub1, n_ext;

  assign op_err   = (n_q < WIDTH'(2)) || (c_q >= n_q);
  assign step_idx = cnt - CW'(1);
  assign a_bit    = |(acc & (WIDTH'(1) << step_idx));
  assign d_bit    = |(d_q & (WIDTH'(1) << bit_idx));
  assign mul_last = (cnt == '0);
  assign last_bit = (bit_idx == '0);
  assign mul_b    = (state == SQUARE) ? acc : c_q;
  assign res      = d_bit ? p : acc;

  // One interleaved step: 2p + a_i*b < 3n, so two conditional subtractions restore p < n.
  assign n_ext = {2'b00, n_q};
  assign sum   = {1'b0, p, 1'b0} + ({(WIDTH+2){a_bit}} & {2'b00, mul_b});
  assign sub1  = (sum >= n_ext) ? sum - n_ext : sum;
  assign p_nx  = (sub1 >= n_ext) ? WIDTH'(sub1 - n_ext) : WIDTH'(sub1);

  always_comb begin
    state_nx = state;
    valid    = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = op_err ? DONE : SQUARE;
      SQUARE:  if (mul_last) state_nx = MULT;
      MULT:    if (mul_last) state_nx = last_bit ? DONE : SQUARE;
      DONE: begin
        valid    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      n_q     <= '0;
      c_q     <= '0;
      acc     <= '0;
      p       <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      plain   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_q <= d;
            n_q <= n;
            c_q <= cipher;
          end
        end
        LOAD: begin
          acc     <= WIDTH'(1);
          p       <= '0;
          cnt     <= CW'(WIDTH);
          bit_idx <= CW'(WIDTH - 1);
          if (op_err) begin
            plain <= '0;
            err   <= 1'b1;
          end
        end
        SQUARE, MULT: begin
          if (mul_last) begin
            p   <= '0;
            cnt <= CW'(WIDTH);
            if (state == SQUARE) begin
              acc <= p;
            end else begin
              if (d_bit) acc <= p;
              if (last_bit) begin
                plain <= res;
                err   <= 1'b0;
              end else begin
                bit_idx <= bit_idx - CW'(1);
              end
            end
          end else begin
            p   <= p_nx;
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DECRYPTOR_CHECK_EN
  logic [WIDTH-1:0] ref_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      match <= 1'b0;
    end else if (state == IDLE && start) begin
      ref_q <= plain_ref;
    end else if (state == LOAD && op_err) begin
      match <= 1'b0;
    end else if (state == MULT && mul_last && last_bit) begin
      match <= (res == ref_q);
    end
  end
`else
  logic unused_plain_ref;
  assign unused_plain_ref = ^plain_ref;
  assign match            = 1'b0;
`endif

endmodule

// File: tb/tb_decryptor.sv
// Scoreboard bench for decryptor: stimulus pushes reference-model results, a monitor pops on valid.
module tb_decryptor;
  localparam int W       = 25;
  localparam int LAT_OK  = 2 * W * (W + 1) + 2;
  localparam int LAT_ERR = 2;

  typedef struct {
    logic [W-1:0] plain;
    logic         err;
    logic         match;
    int           lat;
    int           t0;
  } exp_t;

  logic         clk, rst_n, start;
  logic [W-1:0] d, n, cipher, plain_ref, plain;
  logic         valid, busy, err, match;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  decryptor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d(d), .n(n), .cipher(cipher),
    .plain_ref(plain_ref), .plain(plain), .valid(valid), .busy(busy), .err(err), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Right-to-left binary exponentiation with 64-bit arithmetic.
  function automatic logic [W-1:0] ref_pow(input longint unsigned c, input longint unsigned e,
                                           input longint unsigned m);
    longint unsigned r, b;
    r = 1;
    b = c % m;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return W'(r % m);
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("plain", plain, mon_e.plain);
        check("err", err, mon_e.err);
        check("match", match, mon_e.match);
        check("latency", cyc - mon_e.t0 + 1, mon_e.lat);
      end
    end
  end

  task automatic issue(input logic [W-1:0] dv, input logic [W-1:0] nv, input logic [W-1:0] cv,
                       input logic [W-1:0] rv, input int hold);
    exp_t e;
    logic bad;
    bad = (nv < 2) || (cv >= nv);
    e.plain = bad ? '0 : ref_pow(cv, dv, nv);
    e.err   = bad;
`ifdef DECRYPTOR_CHECK_EN
    e.match = !bad && (e.plain == rv);
`else
    e.match = 1'b0;
`endif
    e.lat = bad ? LAT_ERR : LAT_OK;
    e.t0  = cyc + 1;
    exp_q.push_back(e);
    d = dv; n = nv; cipher = cv; plain_ref = rv;
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    if (hold == 1) check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < LAT_OK + 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("done_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] dv, input logic [W-1:0] nv, input logic [W-1:0] cv,
                     input logic [W-1:0] rv);
    issue(dv, nv, cv, rv, 1);
    wait_done();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_plain"}, plain, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_match"}, match, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] nv, cv, dv, rv, pv;
    rst_n = 1'b0; start = 1'b0;
    d = '0; n = '0; cipher = '0; plain_ref = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    run(5, 21, 11, 2);
    run(5, 21, 16, 4);
    for (int c = 1; c <= 20; c++) begin
      cv = ref_pow(c, 5, 21);
      run(5, 21, cv, W'(c));
    end
    run(0, 21, 11, 1);
    run(5, 1, 0, 0);
    issue(5, 21, 21, 0, 3);
    wait_done();
    issue(5, 21, 11, 2, 1);
    repeat (10) @(negedge clk);
    d = 0; n = 21; cipher = 3; plain_ref = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    issue(5, 21, 11, 2, 1);
    repeat (499) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(5, 21, 16, 4, 1);
    wait_done();
    pv = ref_pow(2, 16777211, 16777213);
    run(16777211, 16777213, 2, pv);
    for (int k = 0; k < 4; k++) begin
      nv = W'($urandom_range(2, (1 << W) - 1));
      dv = W'($urandom);
      if (k == 3) cv = W'($urandom_range(nv, (1 << W) - 1));
      else        cv = W'($urandom % nv);
      rv = (k[0]) ? ref_pow(cv, dv, nv) : W'($urandom);
      run(dv, nv, cv, rv);
    end
    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decryptor.md
DECRYPTOR -- requirements
Module: decryptor

Interface
REQ-001 Parameter WIDTH, default 25, bit width of key, modulus and data words.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 d  input  WIDTH  private exponent, latched on accepted start.
REQ-006 n  input  WIDTH  modulus, latched on accepted start.
REQ-007 cipher  input  WIDTH  ciphertext word, latched on accepted start.
REQ-008 plain_ref  input  WIDTH  expected plaintext, used only with DECRYPTOR_CHECK_EN.
REQ-009 plain  output  WIDTH  result cipher^d mod n; held until the next accepted start.
REQ-010 valid  output  1  one-cycle pulse marking plain, err and match as updated.
REQ-011 busy  output  1  high from the cycle after an accepted start until the cycle of valid.
REQ-012 err  output  1  operand error for the last operation; held with plain.
REQ-013 match  output  1  plain equals plain_ref, sampled at valid; held with plain.

Function
REQ-014 The block SHALL accept start only when busy=0; start while busy=1 SHALL be ignored.
REQ-015 On acceptance the block SHALL latch d, n, cipher and plain_ref; later input changes SHALL NOT affect the running operation.
REQ-016 Exponentiation SHALL be MSB-first square-and-multiply over all WIDTH bits of d: acc=1; per bit acc=acc*acc mod n, then t=acc*cipher mod n, acc=t if the bit is 1.
REQ-017 The multiply step SHALL be computed every bit, regardless of its value, so that latency is constant.
REQ-018 Each modular multiply SHALL use interleaved shift-add with conditional subtraction of n.
  - Takes WIDTH+1 cycles.
  - Internal sum is WIDTH+2 bits wide, so no overflow for any n < 2^WIDTH.
REQ-019 Normal latency: valid SHALL assert exactly 2*WIDTH*(WIDTH+1)+2 cycles after the accepting edge (1302 for WIDTH=25).
REQ-020 Error fast path, if n<2 or cipher>=n:
  - valid asserts 2 cycles after the accepting edge.
  - plain=0, err=1, match=0.
REQ-021 d=0 with valid operands SHALL yield plain=1, err=0.
REQ-022 Internal states SHALL be IDLE, LOAD, SQUARE, MULT, DONE.
  - IDLE->LOAD on accepted start.
  - LOAD->DONE on operand error, otherwise LOAD->SQUARE.
  - SQUARE->MULT.
  - MULT->SQUARE for the next bit, or MULT->DONE after bit 0.
  - DONE->IDLE.
REQ-023 valid SHALL be high only in the DONE cycle; start arriving in that same cycle SHALL be ignored.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and clear plain, valid, busy, err and match to 0, including mid-operation.
REQ-025 After rst_n deasserts, the block SHALL accept start on the first rising edge.
REQ-026 An aborted operation SHALL never produce valid.

Configuration
REQ-027 Macro DECRYPTOR_CHECK_EN defined:
  - match = (plain == plain_ref) for the completed operation, updated at valid.
  - match is 0 on the error path.
REQ-028 Macro DECRYPTOR_CHECK_EN undefined:
  - plain_ref is ignored and no comparator is built.
  - match is tied to 0.

Verification
REQ-029 n=21, d=5, cipher=11, plain_ref=2 -> valid after 1302 cycles, plain=2, err=0, match=1 (with macro).
REQ-030 n=21, d=5, cipher=16 -> plain=4; sweep cipher=c^5 mod 21 for c=1..20 -> plain=c each time.
REQ-031 n=21, d=0, cipher=11 -> plain=1; n=1, cipher=0 -> err=1, plain=0, valid 2 cycles after start.
REQ-032 n=21, cipher=21 -> err=1, plain=0; start pulsed during busy -> ignored, with a single valid produced.
REQ-033 rst_n low at cycle 500 of an operation -> all outputs 0 at once, no valid; a new start completes normally.
REQ-034 n=16777213, d=16777211, cipher=2 -> plain matches a bench reference model; without the macro, match stays 0.
